// File: rtl/parameters_pkg.sv
// System-wide parameters shared by the field-arithmetic units and their arbiters.
package parameters_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int NUM_MUL_REQ = 4;

    typedef enum logic [1:0] {
        ARB_DRAIN,
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/mul_mont_arbiter_rr_select.sv
// Round-robin pick: first set bit of req strictly after last, wrapping at NUM_REQ.
module rr_select #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest requester is written last and wins.
    always_comb begin
        grant_idx = '0;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (req[cand]) begin
                grant_idx = cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mul_mont_arbiter.sv
// Shares one mul_mont multiplier between NUM_REQ requesters with round-robin grants and a done watchdog.
// state | meaning: DRAIN wait out a pre-reset op | IDLE grant next requester | WAIT multiplier owned
module mul_mont_arbiter
    import parameters_pkg::*;
#(
    parameter int NUM_REQ        = NUM_MUL_REQ,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          busy,
    output logic                          timeout_err,
    output logic                          mul_start,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    input  logic [DATA_WIDTH-1:0]         mul_result,
    input  logic                          mul_done
);
    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    arb_state_t              state, state_nxt;
    logic [WDOG_W-1:0]       wdog, wdog_nxt;
    logic [IDX_W-1:0]        owner, owner_nxt;
    logic [IDX_W-1:0]        last_grant, last_grant_nxt;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_any;
    logic [NUM_REQ-1:0]      req_ready_nxt, rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   rsp_result_nxt, mul_a_nxt, mul_b_nxt;
    logic                    mul_start_nxt, timeout_err_nxt;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .req       (req_valid),
        .last      (last_grant),
        .grant_idx (win_idx),
        .any       (win_any)
    );

    assign busy = (state == ARB_WAIT);

    always_comb begin
        state_nxt       = state;
        wdog_nxt        = wdog;
        owner_nxt       = owner;
        last_grant_nxt  = last_grant;
        req_ready_nxt   = '0;
        rsp_valid_nxt   = '0;
        rsp_result_nxt  = rsp_result;
        mul_start_nxt   = 1'b0;
        mul_a_nxt       = mul_a;
        mul_b_nxt       = mul_b;
        timeout_err_nxt = timeout_err;
        case (state)
            ARB_DRAIN: begin
                if (mul_done || wdog == WDOG_LAST) begin
                    state_nxt = ARB_IDLE;
                end else begin
                    wdog_nxt = wdog + WDOG_W'(1);
                end
            end
            ARB_IDLE: begin
                if (win_any) begin
                    mul_a_nxt              = req_a[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    mul_b_nxt              = req_b[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    req_ready_nxt[win_idx] = 1'b1;
                    mul_start_nxt          = 1'b1;
                    owner_nxt              = win_idx;
                    last_grant_nxt         = win_idx;
                    wdog_nxt               = '0;
                    state_nxt              = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                // mul_start is still high in the first WAIT cycle; a done then is stale.
                if (mul_done && !mul_start) begin
                    rsp_result_nxt       = mul_result;
                    rsp_valid_nxt[owner] = 1'b1;
                    state_nxt            = ARB_IDLE;
                end else if (wdog == WDOG_LAST) begin
                    timeout_err_nxt      = 1'b1;
                    rsp_result_nxt       = '0;
                    rsp_valid_nxt[owner] = 1'b1;
                    state_nxt            = ARB_IDLE;
                end else begin
                    wdog_nxt = wdog + WDOG_W'(1);
                end
            end
            default: state_nxt = ARB_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_DRAIN;
            wdog        <= '0;
            owner       <= '0;
            last_grant  <= IDX_LAST;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            wdog        <= wdog_nxt;
            owner       <= owner_nxt;
            last_grant  <= last_grant_nxt;
            req_ready   <= req_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_result  <= rsp_result_nxt;
            mul_start   <= mul_start_nxt;
            mul_a       <= mul_a_nxt;
            mul_b       <= mul_b_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule
